// File: rtl/trng_collector.sv
// trng_collector: ring-oscillator entropy collector -> word assembler -> output word FIFO.
// Define TRNG_COLLECTOR_VON_NEUMANN_EN to insert a Von Neumann debiaser ahead of the assembler.

module trng_sync_lane (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q
);
   logic meta;

   always_ff @(posedge clk) begin
      if (rst) begin
         meta <= 1'b0;
         q    <= 1'b0;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end
endmodule

module trng_collector #(
   parameter int  NUM_SRC    = 4,
   parameter int  VEC_W      = 8,
   parameter int  FIFO_DEPTH = 4,
   parameter int  SAMPLE_DIV = 1,
   localparam int SEL_W      = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1,
   localparam int AW         = $clog2(FIFO_DEPTH),
   localparam int LVL_W      = AW + 1,
   localparam int CNT_W      = $clog2(VEC_W)
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               en,
   input  logic [NUM_SRC-1:0] src_bits,
   input  logic [SEL_W-1:0]   src_sel,
   input  logic               mode,
   input  logic               out_ready,
   input  logic               clr_ovf,
   output logic [VEC_W-1:0]   out_data,
   output logic               out_valid,
   output logic [LVL_W-1:0]   level,
   output logic               overflow
);
   localparam logic [8:0]       DIV_LAST = 9'(SAMPLE_DIV - 1);
   localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(VEC_W - 1);
   localparam logic [SEL_W:0]   SRC_CNT  = (SEL_W + 1)'(NUM_SRC);
   localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(FIFO_DEPTH);

   typedef struct packed {
      logic             vld;
      logic [VEC_W-1:0] word;
   } push_t;

   // ---------------- input synchronisers ----------------
   logic [NUM_SRC-1:0] sync;

   for (genvar i = 0; i < NUM_SRC; i++) begin : g_sync
      trng_sync_lane u_lane (
         .clk (clk),
         .rst (rst),
         .d   (src_bits[i]),
         .q   (sync[i])
      );
   end

   // ---------------- sample strobe ----------------
   logic [8:0] div_cnt;
   logic       strobe;

   assign strobe = en && (div_cnt == DIV_LAST);

   always_ff @(posedge clk) begin
      if (rst)         div_cnt <= '0;
      else if (strobe) div_cnt <= '0;
      else if (en)     div_cnt <= div_cnt + 9'd1;
   end

   // ---------------- source select / config tracking ----------------
   logic [SEL_W-1:0] prev_sel;
   logic             prev_mode;
   logic             cfg_chg;
   logic             sel_ok;
   logic [SEL_W-1:0] sel_eff;
   logic             raw;
   logic             samp;

   // Capture the live config during reset so a config held across reset is not seen as a change.
   always_ff @(posedge clk) begin
      prev_sel  <= src_sel;
      prev_mode <= mode;
   end

   assign cfg_chg = (src_sel != prev_sel) || (mode != prev_mode);
   assign sel_ok  = ({1'b0, src_sel} < SRC_CNT);
   assign sel_eff = sel_ok ? src_sel : '0;
   assign raw     = mode ? ^sync : sync[sel_eff];
   // A sample taken in the cycle the config changes belongs to neither word; drop it.
   assign samp    = strobe && !cfg_chg;

   // ---------------- optional debiaser ----------------
   logic acc_vld;
   logic acc_bit;

`ifdef TRNG_COLLECTOR_VON_NEUMANN_EN
   logic vn_have;
   logic vn_first;

   always_ff @(posedge clk) begin
      if (rst || cfg_chg) begin
         vn_have  <= 1'b0;
         vn_first <= 1'b0;
      end else if (samp) begin
         if (!vn_have) begin
            vn_first <= raw;
            vn_have  <= 1'b1;
         end else begin
            vn_have  <= 1'b0;
         end
      end
   end

   // Pair 01 yields 0, 10 yields 1: the first bit of a differing pair is the output.
   assign acc_vld = samp && vn_have && (vn_first != raw);
   assign acc_bit = vn_first;
`else
   assign acc_vld = samp;
   assign acc_bit = raw;
`endif

   // ---------------- word assembler ----------------
   logic [VEC_W-2:0] part;
   logic [CNT_W-1:0] bit_cnt;
   push_t            push;

   assign push.word = {part, acc_bit};
   assign push.vld  = acc_vld && (bit_cnt == BIT_LAST);

   always_ff @(posedge clk) begin
      if (rst || cfg_chg) begin
         part    <= '0;
         bit_cnt <= '0;
      end else if (acc_vld) begin
         part    <= push.word[VEC_W-2:0];
         bit_cnt <= push.vld ? '0 : bit_cnt + CNT_W'(1);
      end
   end

   // ---------------- output FIFO ----------------
   logic [VEC_W-1:0] mem [FIFO_DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [LVL_W-1:0] count;
   logic             full;
   logic             pop;
   logic             wr_en;
   logic             drop;

   assign full  = (count == LVL_FULL);
   assign pop   = out_valid && out_ready;
   // When full, a same-cycle pop frees the slot the write lands in.
   assign wr_en = push.vld && (!full || pop);
   assign drop  = push.vld && full && !pop;

   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_ptr] <= push.word;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (wr_en) wr_ptr <= wr_ptr + AW'(1);
         if (pop)   rd_ptr <= rd_ptr + AW'(1);
         case ({wr_en, pop})
            2'b10:   count <= count + LVL_W'(1);
            2'b01:   count <= count - LVL_W'(1);
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst)          overflow <= 1'b0;
      else if (drop)    overflow <= 1'b1;
      else if (clr_ovf) overflow <= 1'b0;
   end

   assign out_valid = (count != '0);
   assign level     = count;
   assign out_data  = out_valid ? mem[rd_ptr] : '0;

endmodule

// File: tb/tb_trng_collector.sv
// Directed bench for trng_collector: reference bit model feeds a scoreboard of expected words,
// compared when the DUT presents them on its output.

module tb_trng_collector;
   logic       clk = 1'b0;
   logic       rst;
   logic       en;
   logic [3:0] src_bits;
   logic [1:0] src_sel;
   logic       mode;
   logic       out_ready;
   logic       clr_ovf;
   logic [7:0] out_data;
   logic       out_valid;
   logic [2:0] level;
   logic       overflow;

   int n_chk  = 0;
   int n_fail = 0;

   logic [7:0] sb[$];
   logic [3:0] stim[$];
   logic [6:0] mw;
   int         mc;
   logic       m_ovf;
   logic       vn_have;
   logic       vn_first;

   always #5 clk = ~clk;

   trng_collector #(
      .NUM_SRC    (4),
      .VEC_W      (8),
      .FIFO_DEPTH (4),
      .SAMPLE_DIV (1)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .en        (en),
      .src_bits  (src_bits),
      .src_sel   (src_sel),
      .mode      (mode),
      .out_ready (out_ready),
      .clr_ovf   (clr_ovf),
      .out_data  (out_data),
      .out_valid (out_valid),
      .level     (level),
      .overflow  (overflow)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic model_discard();
      mw       = '0;
      mc       = 0;
      vn_have  = 1'b0;
      vn_first = 1'b0;
   endtask

   task automatic model_bit(input logic b);
      logic [7:0] w;
      w  = {mw, b};
      mw = w[6:0];
      if (mc == 7) begin
         mc = 0;
         if (sb.size() < 4) sb.push_back(w);
         else               m_ovf = 1'b1;
      end else begin
         mc++;
      end
   endtask

   task automatic model_sample(input logic b);
`ifdef TRNG_COLLECTOR_VON_NEUMANN_EN
      if (!vn_have) begin
         vn_first = b;
         vn_have  = 1'b1;
      end else begin
         vn_have = 1'b0;
         if (vn_first != b) model_bit(vn_first);
      end
`else
      model_bit(b);
`endif
   endtask

   function automatic logic samp_of(input logic [3:0] v);
      return mode ? ^v : v[src_sel];
   endfunction

   // ch < 0: all lines random; otherwise line ch carries pat MSB-first, other lines random.
   task automatic gen(input int ch, input logic [31:0] pat, input int n);
      logic [3:0] v;
      for (int i = 0; i < n; i++) begin
         v = 4'($urandom);
         if (ch >= 0) v[ch] = pat[n-1-i];
         stim.push_back(v);
      end
   endtask

   // Drives stim one vector per cycle; en opens two cycles later to line up with the synchroniser.
   task automatic run_stream(input bit pop_last);
      int n;
      n = stim.size();
      for (int s = 0; s < n + 2; s++) begin
         if (s < n) src_bits = stim[s];
         en = (s >= 2);
         if (pop_last && s == n + 1) begin
            if (sb.size() != 0) chk("pop_on_push_head", out_data, sb.pop_front());
            out_ready = 1'b1;
         end
         tick();
      end
      en        = 1'b0;
      out_ready = 1'b0;
      foreach (stim[i]) model_sample(samp_of(stim[i]));
      stim.delete();
   endtask

   task automatic pop_check(input string tag);
      chk({tag, "_valid"}, out_valid, 1);
      if (sb.size() != 0) chk(tag, out_data, sb.pop_front());
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
   endtask

   task automatic set_cfg(input logic m, input logic [1:0] sel);
      mode    = m;
      src_sel = sel;
      tick();
      model_discard();
   endtask

   // Reset is asserted with en/out_ready/clr_ovf all high to show it overrides them.
   task automatic do_reset(input string tag);
      rst       = 1'b1;
      en        = 1'b1;
      out_ready = 1'b1;
      clr_ovf   = 1'b1;
      tick();
      tick();
      chk({tag, "_out_valid"}, out_valid, 0);
      chk({tag, "_level"},     level,     0);
      chk({tag, "_overflow"},  overflow,  0);
      chk({tag, "_out_data"},  out_data,  8'h00);
      rst       = 1'b0;
      en        = 1'b0;
      out_ready = 1'b0;
      clr_ovf   = 1'b0;
      sb.delete();
      m_ovf = 1'b0;
      model_discard();
   endtask

   initial begin
      src_bits = '0;
      src_sel  = 2'd2;
      mode     = 1'b0;
      do_reset("reset");

      // single channel 2 word
      gen(2, 32'hB2, 8);
      run_stream(0);
      chk("b2_level", level, 1);
`ifndef TRNG_COLLECTOR_VON_NEUMANN_EN
      chk("b2_const", out_data, 8'hB2);
`endif
      pop_check("b2_word");
      chk("b2_level_after_pop", level, 0);

      // word split by an en=0 gap continues where it stopped
      gen(2, 32'h5, 3);
      run_stream(0);
      repeat (5) tick();
      chk("freeze_no_word", out_valid, 0);
      gen(2, 32'h19, 5);
      run_stream(0);
      pop_check("freeze_word");

      // partial word on channel 0 discarded by select change
      set_cfg(0, 2'd0);
      gen(0, 32'h1F, 5);
      run_stream(0);
      chk("chg_partial_empty", out_valid, 0);
      set_cfg(0, 2'd1);
      gen(1, 32'h5C, 8);
      run_stream(0);
      chk("chg_level", level, 1);
`ifndef TRNG_COLLECTOR_VON_NEUMANN_EN
      chk("chg_const", out_data, 8'h5C);
`endif
      pop_check("chg_word");

      // XOR of all sources
      set_cfg(1, 2'd2);
      gen(-1, 32'h0, 8);
      run_stream(0);
      pop_check("xor_word");

      // fill past capacity with consumer stalled
      set_cfg(1, 2'd0);
      gen(-1, 32'h0, 40);
      run_stream(0);
      chk("ovf_level", level, sb.size());
      chk("ovf_flag", overflow, m_ovf);
      chk("ovf_valid", out_valid, 1);
      if (sb.size() != 0) chk("ovf_head", out_data, sb[0]);
      clr_ovf = 1'b1;
      tick();
      clr_ovf = 1'b0;
      m_ovf   = 1'b0;
      chk("clr_ovf_flag", overflow, 0);
      chk("clr_ovf_level", level, sb.size());

      // push and pop in the same cycle while full
      gen(-1, 32'h0, 8);
      run_stream(1);
      chk("full_pp_level", level, 4);
      chk("full_pp_ovf", overflow, 0);
      for (int i = 0; i < 4; i++) pop_check($sformatf("drain%0d", i));
      chk("drain_level", level, 0);

      // reset mid-word with a word queued
      set_cfg(0, 2'd3);
      gen(3, 32'h7FF, 11);
      run_stream(0);
      chk("pre_rst_level", level, 1);
      do_reset("mid_reset");
      gen(3, 32'hA6, 8);
      run_stream(0);
      chk("post_rst_level", level, 1);
`ifndef TRNG_COLLECTOR_VON_NEUMANN_EN
      chk("post_rst_const", out_data, 8'hA6);
`endif
      pop_check("post_rst_word");

`ifdef TRNG_COLLECTOR_VON_NEUMANN_EN
      do_reset("vn_reset");
      gen(3, 32'h6CA59, 20);
      run_stream(0);
      chk("vn_const", out_data, 8'h72);
      pop_check("vn_word");
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
